// File: rtl/key_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : key_cmd_ctrl
//  Purpose  : Keyboard command front-end. Registers raw key levels, produces
//             one-cycle press pulses with typematic auto-repeat, per-key
//             toggle latches and a saturating power-of-two zoom register.
//  Revision : 1.0  initial release
// ============================================================================
module key_cmd_ctrl #(
    parameter int                N_KEYS       = 16,
    parameter logic [N_KEYS-1:0] RPT_MASK     = '0,
    parameter logic [N_KEYS-1:0] TOG_MASK     = '0,
    parameter int                ZIN_IDX      = 0,
    parameter int                ZOUT_IDX     = 1,
    parameter int                ZOOM_MAX_LOG = 7,
    parameter int                ZOOM_RST_LOG = 3,
    parameter int                RPT_DELAY    = 25_000_000,
    parameter int                RPT_PERIOD   = 5_000_000,
    parameter int                CNT_W        = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_KEYS-1:0]       keys,
    output logic [N_KEYS-1:0]       key_level,
    output logic [N_KEYS-1:0]       key_pulse,
    output logic [N_KEYS-1:0]       toggle_q,
    output logic [ZOOM_MAX_LOG:0]   view_width,
    output logic                    zoom_at_min,
    output logic                    zoom_at_max
);

    localparam int c_IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int c_ZL_W  = (ZOOM_MAX_LOG > 0) ? $clog2(ZOOM_MAX_LOG + 1) : 1;
    localparam int c_VW_W  = ZOOM_MAX_LOG + 1;
    localparam logic [CNT_W-1:0]  c_DELAY_TC  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0]  c_PERIOD_TC = CNT_W'(RPT_PERIOD - 1);
    localparam logic [c_ZL_W-1:0] c_ZOOM_MAX  = c_ZL_W'(ZOOM_MAX_LOG);
    localparam logic [c_ZL_W-1:0] c_ZOOM_RST  = c_ZL_W'(ZOOM_RST_LOG);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RPT   = 2'd2
    } rpt_state_t;

    logic [N_KEYS-1:0]  r_keys_q;
    logic [N_KEYS-1:0]  r_prev;
    logic [N_KEYS-1:0]  r_key_pulse;
    logic [N_KEYS-1:0]  r_toggle;
    logic [c_ZL_W-1:0]  r_zoom_log;

    rpt_state_t         r_state;
    rpt_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [c_IDX_W-1:0] r_rpt_idx;
    logic [c_IDX_W-1:0] w_rpt_idx_nxt;

    logic [N_KEYS-1:0]  w_rise;
    logic [N_KEYS-1:0]  w_elig;
    logic               w_elig_any;
    logic [c_IDX_W-1:0] w_new_idx;
    logic               w_rpt_fire;
    logic [N_KEYS-1:0]  w_rpt_onehot;
    logic               w_zin;
    logic               w_zout;
    logic               w_at_min;
    logic               w_at_max;

    assign w_rise     = r_keys_q & ~r_prev;
    assign w_elig     = w_rise & RPT_MASK;
    assign w_elig_any = |w_elig;

    // Key sampling and edge history; reset loads both stages so held keys never edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys_q <= keys;
            r_prev   <= keys;
        end else begin
            r_keys_q <= keys;
            r_prev   <= r_keys_q;
        end
    end

    // Lowest-index eligible rise wins when several arrive together
    always_comb begin
        w_new_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (w_elig[i]) w_new_idx = c_IDX_W'(i);
        end
    end

    // Repeat engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            r_rpt_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rpt_idx <= w_rpt_idx_nxt;
        end
    end

    // Repeat engine next state: new rise beats release, release beats terminal count
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rpt_idx_nxt = r_rpt_idx;
        w_rpt_fire    = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (w_elig_any) begin
                    w_rpt_idx_nxt = w_new_idx;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = R_DELAY;
                end
            end
            R_DELAY, R_RPT: begin
                if (w_elig_any) begin
                    w_rpt_idx_nxt = w_new_idx;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = R_DELAY;
                end else if (!r_keys_q[r_rpt_idx]) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = R_IDLE;
                end else if (r_cnt == ((r_state == R_DELAY) ? c_DELAY_TC : c_PERIOD_TC)) begin
                    w_rpt_fire  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = R_RPT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = R_IDLE;
            end
        endcase
    end

    // Decode the repeat request onto the key it belongs to
    always_comb begin
        w_rpt_onehot = '0;
        if (w_rpt_fire) w_rpt_onehot[r_rpt_idx] = 1'b1;
    end

    // Registered command pulses; a coincident rise and repeat merge into one pulse
    always_ff @(posedge clk) begin
        if (rst) r_key_pulse <= '0;
        else     r_key_pulse <= w_rise | w_rpt_onehot;
    end

    // Toggle latches flip on genuine press edges of masked keys only
    always_ff @(posedge clk) begin
        if (rst) r_toggle <= '0;
        else     r_toggle <= r_toggle ^ (w_rise & TOG_MASK);
    end

    assign w_zin    = r_key_pulse[ZIN_IDX];
    assign w_zout   = r_key_pulse[ZOUT_IDX];
    assign w_at_min = (r_zoom_log == '0);
    assign w_at_max = (r_zoom_log == c_ZOOM_MAX);

    // Saturating zoom exponent; simultaneous in/out cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zoom_log <= c_ZOOM_RST;
        end else if (w_zin && !w_zout && !w_at_min) begin
            r_zoom_log <= r_zoom_log - c_ZL_W'(1);
        end else if (w_zout && !w_zin && !w_at_max) begin
            r_zoom_log <= r_zoom_log + c_ZL_W'(1);
        end
    end

    assign key_level   = r_keys_q;
    assign key_pulse   = r_key_pulse;
    assign toggle_q    = r_toggle;
    assign view_width  = c_VW_W'(1) << r_zoom_log;
    assign zoom_at_min = w_at_min;
    assign zoom_at_max = w_at_max;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_cmd_ctrl
//  Purpose  : Directed self-checking bench for key_cmd_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keys;
    logic [7:0] key_level;
    logic [7:0] key_pulse;
    logic [7:0] toggle_q;
    logic [7:0] view_width;
    logic       zoom_at_min;
    logic       zoom_at_max;

    int errors = 0;
    int checks = 0;

    key_cmd_ctrl #(
        .N_KEYS      (8),
        .RPT_MASK    (8'h0C),
        .TOG_MASK    (8'h10),
        .ZIN_IDX     (0),
        .ZOUT_IDX    (1),
        .ZOOM_MAX_LOG(7),
        .ZOOM_RST_LOG(3),
        .RPT_DELAY   (8),
        .RPT_PERIOD  (4),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keys       (keys),
        .key_level  (key_level),
        .key_pulse  (key_pulse),
        .toggle_q   (toggle_q),
        .view_width (view_width),
        .zoom_at_min(zoom_at_min),
        .zoom_at_max(zoom_at_max)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        keys = 8'h10;
        step(2);
        checks++;
        if (key_pulse !== 8'h00) begin
            errors++; $display("FAIL rst_pulse: got %h want 00", key_pulse);
        end
        checks++;
        if (toggle_q !== 8'h00) begin
            errors++; $display("FAIL rst_toggle: got %h want 00", toggle_q);
        end
        checks++;
        if (view_width !== 8'd8 || zoom_at_min !== 1'b0 || zoom_at_max !== 1'b0) begin
            errors++;
            $display("FAIL rst_zoom: got vw=%0d min=%b max=%b want vw=8 min=0 max=0",
                     view_width, zoom_at_min, zoom_at_max);
        end
        checks++;
        if (key_level !== 8'h10) begin
            errors++; $display("FAIL rst_level: got %h want 10", key_level);
        end
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            checks++;
            if (key_pulse !== 8'h00) begin
                errors++; $display("FAIL held_thru_rst_pulse c=%0d: got %h want 00", c, key_pulse);
            end
        end
        checks++;
        if (toggle_q !== 8'h00) begin
            errors++; $display("FAIL held_thru_rst_toggle: got %h want 00", toggle_q);
        end
        keys = 8'h00;
        step(3);
        keys = 8'h10;
        step(1);
        checks++;
        if (key_pulse !== 8'h00) begin
            errors++; $display("FAIL press_early: got %h want 00", key_pulse);
        end
        step(1);
        checks++;
        if (key_pulse !== 8'h10) begin
            errors++; $display("FAIL press_pulse: got %h want 10", key_pulse);
        end
        checks++;
        if (toggle_q !== 8'h10) begin
            errors++; $display("FAIL press_toggle: got %h want 10", toggle_q);
        end
        step(1);
        checks++;
        if (key_pulse !== 8'h00) begin
            errors++; $display("FAIL press_one_cycle: got %h want 00", key_pulse);
        end
        keys = 8'h00;
        step(4);
    endtask

    task automatic test_repeat;
        logic [7:0] exp;
        keys = 8'h04;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            exp = (c == 2 || (c >= 10 && ((c - 10) % 4) == 0)) ? 8'h04 : 8'h00;
            checks++;
            if (key_pulse !== exp) begin
                errors++; $display("FAIL repeat c=%0d: got %h want %h", c, key_pulse, exp);
            end
        end
        checks++;
        if (toggle_q !== 8'h10) begin
            errors++; $display("FAIL repeat_no_toggle: got %h want 10", toggle_q);
        end
        keys = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            checks++;
            if (key_pulse !== 8'h00) begin
                errors++; $display("FAIL repeat_release c=%0d: got %h want 00", c, key_pulse);
            end
        end
    endtask

    task automatic test_switch;
        logic [7:0] exp;
        keys = 8'h04;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            if (c == 11) keys = 8'h0C;
            exp = 8'h00;
            if (c == 2 || c == 10) exp = 8'h04;
            if (c == 13 || c == 21 || c == 25 || c == 29) exp = 8'h08;
            checks++;
            if (key_pulse !== exp) begin
                errors++; $display("FAIL switch c=%0d: got %h want %h", c, key_pulse, exp);
            end
        end
        keys = 8'h00;
        step(12);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        keys = 8'h0C;
        for (int c = 1; c <= 16; c++) begin
            step(1);
            exp = 8'h00;
            if (c == 2) exp = 8'h0C;
            if (c == 10 || c == 14) exp = 8'h04;
            checks++;
            if (key_pulse !== exp) begin
                errors++; $display("FAIL simul_rise c=%0d: got %h want %h", c, key_pulse, exp);
            end
        end
        keys = 8'h00;
        step(12);
    endtask

    task automatic test_zoom;
        int exp;
        rst  = 1'b1;
        keys = 8'h00;
        step(1);
        rst = 1'b0;
        step(1);
        for (int p = 1; p <= 10; p++) begin
            keys = 8'h02;
            step(1);
            keys = 8'h00;
            step(4);
            exp = (p >= 4) ? 128 : (8 << p);
            checks++;
            if (view_width !== 8'(exp)) begin
                errors++; $display("FAIL zoom_out p=%0d: got %0d want %0d", p, view_width, exp);
            end
        end
        checks++;
        if (zoom_at_max !== 1'b1 || zoom_at_min !== 1'b0) begin
            errors++; $display("FAIL zoom_at_max: got max=%b min=%b want max=1 min=0",
                               zoom_at_max, zoom_at_min);
        end
        for (int p = 1; p <= 8; p++) begin
            keys = 8'h01;
            step(1);
            keys = 8'h00;
            step(4);
            exp = (p >= 7) ? 1 : (128 >> p);
            checks++;
            if (view_width !== 8'(exp)) begin
                errors++; $display("FAIL zoom_in p=%0d: got %0d want %0d", p, view_width, exp);
            end
        end
        checks++;
        if (zoom_at_min !== 1'b1 || zoom_at_max !== 1'b0) begin
            errors++; $display("FAIL zoom_at_min: got min=%b max=%b want min=1 max=0",
                               zoom_at_min, zoom_at_max);
        end
    endtask

    task automatic test_zoom_both;
        rst  = 1'b1;
        keys = 8'h00;
        step(1);
        rst = 1'b0;
        step(1);
        keys = 8'h03;
        step(1);
        keys = 8'h00;
        step(1);
        checks++;
        if (key_pulse !== 8'h03) begin
            errors++; $display("FAIL both_pulse: got %h want 03", key_pulse);
        end
        step(3);
        checks++;
        if (view_width !== 8'd8) begin
            errors++; $display("FAIL both_zoom: got %0d want 8", view_width);
        end
    endtask

    task automatic test_reset_mid_repeat;
        keys = 8'h04;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (key_pulse !== 8'h00) begin
            errors++; $display("FAIL midrpt_rst_pulse: got %h want 00", key_pulse);
        end
        for (int c = 1; c <= 20; c++) begin
            step(1);
            checks++;
            if (key_pulse !== 8'h00) begin
                errors++; $display("FAIL midrpt_after c=%0d: got %h want 00", c, key_pulse);
            end
        end
        checks++;
        if (key_level !== 8'h04) begin
            errors++; $display("FAIL midrpt_level: got %h want 04", key_level);
        end
        keys = 8'h00;
        step(4);
    endtask

    initial begin
        rst  = 1'b1;
        keys = 8'h00;
        test_reset();
        test_repeat();
        test_switch();
        test_back_to_back();
        test_zoom();
        test_zoom_both();
        test_reset_mid_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
